cpu_boot_sequencer: RTL
=======================

// Module: cpu_boot_sequencer
// PURPOSE
//  Sequences Single_Cycle_CPU bring-up: holds the core in reset, streams a program image into
//  instruction memory and then a data image into data memory over the ex_* back-door ports.
//  It then releases the core, times the run until flag_done or a timeout, and captures Out_R.
//  Sits between the test/host stream and the CPU; owns the CPU's rst_n and all ex_* inputs.
// PARAMETERS
//  TIMEOUT_CYCLES  32'd100000  max RUN cycles before the run is aborted as TIMEOUT
// PORTS
//  clk_i        in   1   system clock, same clock as the CPU's clk_i
//  rst_n        in   1   async active-low reset
//  start        in   1   1-cycle pulse; begins a load+run sequence from IDLE/DONE/TIMEOUT
//  abort        in   1   forces return to IDLE from any state
//  cfg_icount   in  16   instruction words to load, sampled on accepted start
//  cfg_dcount   in  16   data words to load, sampled on accepted start
//  s_valid      in   1   image stream word valid
//  s_data       in  16   image stream word; instr words first, then data words
//  s_ready      out  1   sequencer accepts s_data this cycle
//  cpu_rst_n    out  1   drives the CPU rst_n
//  ex_iwe       out  1   imem write enable to the CPU
//  ex_iaddr     out 16   imem write address
//  ex_idata     out 16   imem write data
//  ex_dwe       out  1   dmem write enable to the CPU
//  ex_daddr     out 16   dmem write address
//  ex_ddata     out 16   dmem write data
//  flag_done    in   1   CPU halted (Hlt & rst_n)
//  out_r        in  16   CPU Out_R
//  busy         out  1   state not in {IDLE, DONE, TIMEOUT}
//  done         out  1   state == DONE
//  timeout      out  1   state == TIMEOUT
//  cycle_count  out 32   RUN cycles of the last/current run
//  last_out_r   out 16   most recent nonzero out_r seen during RUN
//  out_events   out  8   count of RUN cycles with out_r != 0, saturating at 255
// BEHAVIOUR
//  Reset: state=IDLE; cpu_rst_n=0; s_ready=0; ex_* all 0; cycle_count=0; last_out_r=0;
//  out_events=0.
//  All outputs are registered. cpu_rst_n is 1 only in RUN and DONE.
//  States: IDLE, LOAD_I, LOAD_D, RELEASE, RUN, DONE, TIMEOUT.
//  Accepted start, from IDLE/DONE/TIMEOUT only:
//   - latch counts; clear cycle_count, last_out_r and out_events; zero the addr counter.
//   - next state: LOAD_I; LOAD_D if icount=0; RELEASE if both counts are 0.
//   - start is ignored while busy.
//  LOAD_I/LOAD_D:
//   - s_ready=1; a beat is s_valid&s_ready.
//   - beat in cycle k -> ex_iwe (LOAD_I) or ex_dwe (LOAD_D)=1 in k+1, addr=counter, data=s_data.
//   - the write strobe is high for exactly 1 cycle per beat; addr counts 0..count-1.
//   - on the beat that makes addr==count-1: s_ready drops next cycle, addr resets to 0, and the
//     state advances to LOAD_D (or to RELEASE if dcount=0); LOAD_I->LOAD_D likewise.
//   - s_valid=0 stalls with no write; s_data is don't-care when s_ready=0.
//  RELEASE: exactly 1 cycle; the last write strobe completes, ex_* are 0, cpu_rst_n=0.
//   Next state: RUN.
//  RUN: cpu_rst_n=1, ex_*=0.
//   - cycle_count increments every RUN cycle, saturating at 2^32-1.
//   - out_r != 0 -> last_out_r<=out_r, out_events++.
//   - flag_done=1 -> DONE, and that cycle is not counted.
//   - else cycle_count==TIMEOUT_CYCLES-1 -> TIMEOUT.
//  DONE: holds the CPU out of reset (halted, its clock gated by flag_done); results are frozen.
//  TIMEOUT: cpu_rst_n=0; results are frozen.
//  abort (priority over start and all transitions):
//   - next cycle: IDLE, cpu_rst_n=0, s_ready=0, ex_*=0.
//   - cycle_count, last_out_r and out_events hold their values.
//  Async reset mid-load/run: outputs take reset values immediately; a partial image is not
//   rolled back.
//  Widths: addresses are 16-bit, so count=65535 loads words 0..65534; count arithmetic never
//   wraps.
// TESTING
//  - icount=3, dcount=2, s_valid always 1 -> ex_iwe writes 0..2 then ex_dwe writes 0..1, each
//    1 cycle wide; RELEASE 1 cycle; cpu_rst_n rises 7 cycles after start.
//  - s_valid toggles 1,0,1,0 -> no strobe on 0 cycles, addresses contiguous, no dropped or
//    duplicated words.
//  - icount=0, dcount=0 -> IDLE->RELEASE->RUN; cpu_rst_n=1 two cycles after start.
//  - program "LDI R1,5; OUTR R1; HLT" -> done=1, last_out_r=16'd5, out_events=1, cycle_count=3.
//  - tight-loop program with TIMEOUT_CYCLES=50 -> timeout=1 with cycle_count=49, cpu_rst_n=0.
//  - abort mid-LOAD_D, then start during RUN of a new run, then rst_n low mid-RUN -> IDLE with
//    all ex_*=0; start ignored while busy; all outputs at reset values.

Source files
------------

// File: rtl/cpu_boot_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_boot_sequencer_if
//
// Purpose:
//   Bundles the two handshake/bus groups that the boot sequencer sits between:
//   the incoming image stream from the host and the back-door / control port
//   of the Single_Cycle_CPU (reset, imem/dmem write ports, halt flag, Out_R).
//
// Signals:
//   s_valid    host -> seq   image stream word valid
//   s_data     host -> seq   image stream word (instr words first, then data)
//   s_ready    seq  -> host  sequencer accepts s_data this cycle
//   cpu_rst_n  seq  -> cpu   CPU active-low reset
//   ex_iwe     seq  -> cpu   imem write enable
//   ex_iaddr   seq  -> cpu   imem write address
//   ex_idata   seq  -> cpu   imem write data
//   ex_dwe     seq  -> cpu   dmem write enable
//   ex_daddr   seq  -> cpu   dmem write address
//   ex_ddata   seq  -> cpu   dmem write data
//   flag_done  cpu  -> seq   CPU halted
//   out_r      cpu  -> seq   CPU Out_R register
//
// Modports:
//   master  the sequencer side (drives s_ready, cpu_rst_n and all ex_*)
//   slave   the host + CPU side (drives the stream and the CPU status)
// ---------------------------------------------------------------------------
interface cpu_boot_sequencer_if;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        cpu_rst_n;
    logic        ex_iwe;
    logic [15:0] ex_iaddr;
    logic [15:0] ex_idata;
    logic        ex_dwe;
    logic [15:0] ex_daddr;
    logic [15:0] ex_ddata;
    logic        flag_done;
    logic [15:0] out_r;

    modport master (
        input  s_valid,
        input  s_data,
        input  flag_done,
        input  out_r,
        output s_ready,
        output cpu_rst_n,
        output ex_iwe,
        output ex_iaddr,
        output ex_idata,
        output ex_dwe,
        output ex_daddr,
        output ex_ddata
    );

    modport slave (
        output s_valid,
        output s_data,
        output flag_done,
        output out_r,
        input  s_ready,
        input  cpu_rst_n,
        input  ex_iwe,
        input  ex_iaddr,
        input  ex_idata,
        input  ex_dwe,
        input  ex_daddr,
        input  ex_ddata
    );
endinterface

// File: rtl/cpu_boot_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_boot_sequencer
//
// Purpose:
//   Brings up the Single_Cycle_CPU. While holding the core in reset it
//   streams a program image into instruction memory and then a data image
//   into data memory through the CPU's ex_* back-door ports. It then releases
//   the core, times the run until the CPU halts (flag_done) or a timeout
//   expires, and records what the program wrote to Out_R.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum number of RUN cycles before the run is abandoned
//
// Ports:
//   clk_i        in   1   system clock, shared with the CPU
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   one-cycle pulse, begins load+run from IDLE/DONE/TIMEOUT
//   abort        in   1   returns to IDLE from any state, wins over everything
//   cfg_icount   in  16   instruction words to load (sampled on accepted start)
//   cfg_dcount   in  16   data words to load (sampled on accepted start)
//   bus          if       master side of cpu_boot_sequencer_if (stream + CPU)
//   busy         out  1   a load or run is in progress
//   done         out  1   the last run ended with the CPU halting
//   timeout      out  1   the last run hit TIMEOUT_CYCLES
//   cycle_count  out 32   RUN cycles of the last/current run
//   last_out_r   out 16   most recent nonzero Out_R seen during RUN
//   out_events   out  8   RUN cycles with Out_R nonzero, saturating at 255
//
// All outputs come straight from flops. Control outputs are registered from
// the next-state value so that they line up with the state they describe.
// ---------------------------------------------------------------------------
module cpu_boot_sequencer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
    input  logic                        clk_i,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [15:0]                 cfg_icount,
    input  logic [15:0]                 cfg_dcount,
    cpu_boot_sequencer_if.master        bus,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout,
    output logic [31:0]                 cycle_count,
    output logic [15:0]                 last_out_r,
    output logic [7:0]                  out_events
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_I  = 3'd1;
    localparam logic [2:0] ST_LOAD_D  = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_RUN     = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_TIMEOUT = 3'd6;

    logic [2:0]  r_state;
    logic [15:0] r_icount;
    logic [15:0] r_dcount;
    logic [15:0] r_addr;

    logic        r_s_ready;
    logic        r_cpu_rst_n;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;

    logic        r_iwe;
    logic [15:0] r_iaddr;
    logic [15:0] r_idata;
    logic        r_dwe;
    logic [15:0] r_daddr;
    logic [15:0] r_ddata;

    logic [31:0] r_cycle_count;
    logic [15:0] r_last_out_r;
    logic [7:0]  r_out_events;

    logic        w_idle_like;
    logic        w_start_ok;
    logic        w_loading;
    logic        w_beat;
    logic [15:0] w_cur_count;
    logic        w_last_beat;
    logic        w_run_live;
    logic        w_at_limit;
    logic [2:0]  w_next_state;

    // Qualifiers shared by the next-state logic and the datapath.
    // The address counter is reused for both images, so the terminal count is
    // whichever image the current load state is filling. A load state is only
    // ever entered with a nonzero count, so count-1 cannot wrap.
    always_comb begin
        w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_TIMEOUT);
        w_start_ok  = start && w_idle_like && !abort;
        w_loading   = (r_state == ST_LOAD_I) || (r_state == ST_LOAD_D);
        w_beat      = w_loading && r_s_ready && bus.s_valid;
        w_cur_count = (r_state == ST_LOAD_I) ? r_icount : r_dcount;
        w_last_beat = w_beat && (r_addr == (w_cur_count - 16'd1));
        w_run_live  = (r_state == ST_RUN) && !bus.flag_done && !abort;
        w_at_limit  = (r_cycle_count == (TIMEOUT_CYCLES - 32'd1));
    end

    // Next-state logic. Abort overrides every transition. Empty images are
    // skipped at start time so a load state never waits on a zero count.
    // The halt check comes before the timeout check so a program that halts
    // on the final allowed cycle is still reported as DONE.
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (start) begin
                        if (cfg_icount != 16'd0) begin
                            w_next_state = ST_LOAD_I;
                        end else if (cfg_dcount != 16'd0) begin
                            w_next_state = ST_LOAD_D;
                        end else begin
                            w_next_state = ST_RELEASE;
                        end
                    end
                end
                ST_LOAD_I: begin
                    if (w_last_beat) begin
                        w_next_state = (r_dcount != 16'd0) ? ST_LOAD_D : ST_RELEASE;
                    end
                end
                ST_LOAD_D: begin
                    if (w_last_beat) begin
                        w_next_state = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    w_next_state = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.flag_done) begin
                        w_next_state = ST_DONE;
                    end else if (w_at_limit) begin
                        w_next_state = ST_TIMEOUT;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State register plus the status/control outputs decoded from the state
    // being entered, so each output is a flop that is valid in that state.
    // s_ready stays high straight across LOAD_I -> LOAD_D, which lets the data
    // image follow the program image with no bubble.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_s_ready   <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_s_ready   <= (w_next_state == ST_LOAD_I) || (w_next_state == ST_LOAD_D);
            r_cpu_rst_n <= (w_next_state == ST_RUN) || (w_next_state == ST_DONE);
            r_busy      <= (w_next_state == ST_LOAD_I) || (w_next_state == ST_LOAD_D) ||
                           (w_next_state == ST_RELEASE) || (w_next_state == ST_RUN);
            r_done      <= (w_next_state == ST_DONE);
            r_timeout   <= (w_next_state == ST_TIMEOUT);
        end
    end

    // Image counts and the shared word address. Counts are captured once per
    // accepted start; the address restarts at 0 for each image and on abort.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_icount <= 16'd0;
            r_dcount <= 16'd0;
            r_addr   <= 16'd0;
        end else begin
            if (w_start_ok) begin
                r_icount <= cfg_icount;
                r_dcount <= cfg_dcount;
                r_addr   <= 16'd0;
            end else if (abort) begin
                r_addr   <= 16'd0;
            end else if (w_beat) begin
                r_addr   <= w_last_beat ? 16'd0 : (r_addr + 16'd1);
            end
        end
    end

    // Back-door write ports. Every accepted stream word produces exactly one
    // single-cycle strobe one cycle later; address and data are forced to 0
    // whenever no write is in flight so the CPU side sees a quiet bus.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_iwe   <= 1'b0;
            r_iaddr <= 16'd0;
            r_idata <= 16'd0;
            r_dwe   <= 1'b0;
            r_daddr <= 16'd0;
            r_ddata <= 16'd0;
        end else begin
            r_iwe   <= 1'b0;
            r_iaddr <= 16'd0;
            r_idata <= 16'd0;
            r_dwe   <= 1'b0;
            r_daddr <= 16'd0;
            r_ddata <= 16'd0;
            if (w_beat && !abort) begin
                if (r_state == ST_LOAD_I) begin
                    r_iwe   <= 1'b1;
                    r_iaddr <= r_addr;
                    r_idata <= bus.s_data;
                end else begin
                    r_dwe   <= 1'b1;
                    r_daddr <= r_addr;
                    r_ddata <= bus.s_data;
                end
            end
        end
    end

    // Run statistics. They are cleared only by an accepted start, so after
    // DONE, TIMEOUT or an abort they keep describing the last run. The cycle
    // in which the CPU reports halt is not part of the run, and the cycle that
    // trips the timeout leaves cycle_count at TIMEOUT_CYCLES-1.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_count <= 32'd0;
            r_last_out_r  <= 16'd0;
            r_out_events  <= 8'd0;
        end else begin
            if (w_start_ok) begin
                r_cycle_count <= 32'd0;
                r_last_out_r  <= 16'd0;
                r_out_events  <= 8'd0;
            end else if (w_run_live) begin
                if (!w_at_limit && (r_cycle_count != 32'hFFFF_FFFF)) begin
                    r_cycle_count <= r_cycle_count + 32'd1;
                end
                if (bus.out_r != 16'd0) begin
                    r_last_out_r <= bus.out_r;
                    if (r_out_events != 8'hFF) begin
                        r_out_events <= r_out_events + 8'd1;
                    end
                end
            end
        end
    end

    assign bus.s_ready   = r_s_ready;
    assign bus.cpu_rst_n = r_cpu_rst_n;
    assign bus.ex_iwe    = r_iwe;
    assign bus.ex_iaddr  = r_iaddr;
    assign bus.ex_idata  = r_idata;
    assign bus.ex_dwe    = r_dwe;
    assign bus.ex_daddr  = r_daddr;
    assign bus.ex_ddata  = r_ddata;

    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;
    assign last_out_r  = r_last_out_r;
    assign out_events  = r_out_events;

endmodule
